// File: rtl/rv32i_mc_control_unit.sv
// Multicycle RV32I main control FSM: sequences fetch/decode/execute/memory/writeback
// and decodes ALU operation and immediate format for the datapath.
package rv32i_mc_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_control_t;
endpackage

module rv32i_mc_control_unit
    import rv32i_mc_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT  = 16,
    parameter bit          TRAP_ILLEGAL = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         ena_i,
    input  logic [31:0]  instruction_i,
    input  logic         mem_ready_i,
    input  logic         equal_i,
    input  logic         alu_lt_i,
    input  logic         alu_ltu_i,
    output logic         mem_req_o,
    output logic         mem_wr_ena_o,
    output logic         pc_ena_o,
    output logic         ir_write_o,
    output logic         reg_write_o,
    output logic         adr_src_o,
    output logic [1:0]   alu_src_a_o,
    output logic [1:0]   alu_src_b_o,
    output logic [1:0]   result_src_o,
    output logic [2:0]   imm_src_o,
    output alu_control_t alu_control_o,
    output logic         halted_o,
    output logic [1:0]   fault_o
);

    // state     | meaning                  state     | meaning
    // FETCH     | IR <- mem[PC], PC += 4   EXEC_I    | A op imm_I
    // DECODE    | alu_out <- PC_old + imm  ALU_WB    | rd <- alu_out
    // MEM_ADR   | alu_out <- A + imm       JAL       | PC <- target
    // MEM_READ  | load, wait mem_ready     JALR      | PC <- A + imm_I
    // MEM_WB    | rd <- loaded data        JAL_LINK  | alu_out <- PC_old + 4
    // MEM_WRITE | store, wait mem_ready    BRANCH    | compare, PC <- target if taken
    // EXEC_R    | A op B                   LUI/AUIPC | U-immediate forms
    // HALT      | trapped until reset
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
        S_EXEC_R, S_EXEC_I, S_ALU_WB, S_JAL, S_JALR, S_JAL_LINK,
        S_BRANCH, S_LUI, S_AUIPC, S_HALT
    } state_t;

    localparam int TW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t        state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [1:0]    fault_q, fault_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       bit30;
    logic       unused_instr_bits;

    assign opcode = instruction_i[6:0];
    assign funct3 = instruction_i[14:12];
    assign bit30  = instruction_i[30];
    assign unused_instr_bits = ^{instruction_i[31], instruction_i[29:15], instruction_i[11:7]};

    logic mem_state, wait_mem, timeout, taken, illegal;

    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
    assign wait_mem  = mem_state && !mem_ready_i && (MEM_TIMEOUT != 0);
    assign timeout   = wait_mem && (cnt_q == TO_LAST);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = equal_i;
            3'b001:  taken = !equal_i;
            3'b100:  taken = alu_lt_i;
            3'b101:  taken = !alu_lt_i;
            3'b110:  taken = alu_ltu_i;
            3'b111:  taken = !alu_ltu_i;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        illegal = 1'b0;
        case (opcode)
            7'h03, 7'h23, 7'h33, 7'h13, 7'h6F, 7'h67, 7'h37, 7'h17: illegal = 1'b0;
            7'h63:   illegal = (funct3[2:1] == 2'b01);
            default: illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            fault_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        if (ena_i) begin
            case (state_q)
                S_FETCH:     if (mem_ready_i) state_d = S_DECODE;
                S_DECODE: begin
                    if (illegal) begin
                        if (TRAP_ILLEGAL) begin
                            state_d = S_HALT;
                            fault_d = 2'b01;
                        end else begin
                            state_d = S_FETCH;
                        end
                    end else begin
                        case (opcode)
                            7'h03, 7'h23: state_d = S_MEM_ADR;
                            7'h33:        state_d = S_EXEC_R;
                            7'h13:        state_d = S_EXEC_I;
                            7'h6F:        state_d = S_JAL;
                            7'h67:        state_d = S_JALR;
                            7'h63:        state_d = S_BRANCH;
                            7'h37:        state_d = S_LUI;
                            default:      state_d = S_AUIPC;
                        endcase
                    end
                end
                S_MEM_ADR:   state_d = (opcode == 7'h23) ? S_MEM_WRITE : S_MEM_READ;
                S_MEM_READ:  if (mem_ready_i) state_d = S_MEM_WB;
                S_MEM_WB:    state_d = S_FETCH;
                S_MEM_WRITE: if (mem_ready_i) state_d = S_FETCH;
                S_EXEC_R:    state_d = S_ALU_WB;
                S_EXEC_I:    state_d = S_ALU_WB;
                S_ALU_WB:    state_d = S_FETCH;
                S_JAL:       state_d = S_ALU_WB;
                S_JALR:      state_d = S_JAL_LINK;
                S_JAL_LINK:  state_d = S_ALU_WB;
                S_BRANCH:    state_d = S_FETCH;
                S_LUI:       state_d = S_ALU_WB;
                S_AUIPC:     state_d = S_ALU_WB;
                default:     state_d = S_HALT;
            endcase
            if (timeout) begin
                state_d = S_HALT;
                fault_d = 2'b10;
            end
            // Any state change restarts the wait count, so each memory state gets a fresh budget.
            if (state_d != state_q) begin
                cnt_d = '0;
            end else if (wait_mem) begin
                cnt_d = cnt_q + TW'(1);
            end
        end
    end

    logic req_raw, wr_raw, pc_raw, irw_raw, rw_raw, en_gate;

    assign en_gate = rst_i && ena_i;

    always_comb begin
        req_raw       = 1'b0;
        wr_raw        = 1'b0;
        pc_raw        = 1'b0;
        irw_raw       = 1'b0;
        rw_raw        = 1'b0;
        adr_src_o     = 1'b0;
        alu_src_a_o   = 2'b00;
        alu_src_b_o   = 2'b00;
        result_src_o  = 2'b00;
        imm_src_o     = 3'b000;
        alu_control_o = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                req_raw      = 1'b1;
                irw_raw      = mem_ready_i;
                pc_raw       = mem_ready_i;
                alu_src_b_o  = 2'b10;
                result_src_o = 2'b10;
            end
            S_DECODE: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b01;
                imm_src_o   = (opcode == 7'h63) ? 3'b010 : 3'b100;
            end
            S_MEM_ADR: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
                imm_src_o   = (opcode == 7'h23) ? 3'b001 : 3'b000;
            end
            S_MEM_READ: begin
                req_raw   = 1'b1;
                adr_src_o = 1'b1;
            end
            S_MEM_WB: begin
                rw_raw       = 1'b1;
                result_src_o = 2'b01;
            end
            S_MEM_WRITE: begin
                req_raw   = 1'b1;
                wr_raw    = mem_ready_i;
                adr_src_o = 1'b1;
            end
            S_EXEC_R, S_EXEC_I: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = (state_q == S_EXEC_I) ? 2'b01 : 2'b00;
                case (funct3)
                    3'b000:  alu_control_o = (state_q == S_EXEC_R && bit30) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control_o = ALU_SLL;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b011:  alu_control_o = ALU_SLTU;
                    3'b100:  alu_control_o = ALU_XOR;
                    3'b101:  alu_control_o = bit30 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control_o = ALU_OR;
                    default: alu_control_o = ALU_AND;
                endcase
            end
            S_ALU_WB:    rw_raw = 1'b1;
            S_JAL: begin
                pc_raw      = 1'b1;
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b10;
            end
            S_JALR: begin
                pc_raw       = 1'b1;
                alu_src_a_o  = 2'b10;
                alu_src_b_o  = 2'b01;
                result_src_o = 2'b10;
            end
            S_JAL_LINK: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b10;
            end
            S_BRANCH: begin
                pc_raw        = taken;
                alu_src_a_o   = 2'b10;
                alu_control_o = ALU_SUB;
            end
            S_LUI: begin
                alu_src_a_o = 2'b11;
                alu_src_b_o = 2'b01;
                imm_src_o   = 3'b011;
            end
            S_AUIPC: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b01;
                imm_src_o   = 3'b011;
            end
            default: ;
        endcase
    end

    // A timing-out cycle has mem_ready low, so the ready-gated strobes are already quiet.
    assign mem_req_o    = req_raw && en_gate;
    assign mem_wr_ena_o = wr_raw && en_gate;
    assign pc_ena_o     = pc_raw && en_gate;
    assign ir_write_o   = irw_raw && en_gate;
    assign reg_write_o  = rw_raw && en_gate;
    assign halted_o     = (state_q == S_HALT);
    assign fault_o      = fault_q;

endmodule

// File: tb/tb_rv32i_mc_control_unit.sv
// Directed bench for rv32i_mc_control_unit: per-cycle vector table plus
// hand-written timeout and wait-counter sequences.
module tb_rv32i_mc_control_unit;
    import rv32i_mc_pkg::*;

    localparam logic [31:0] I_ADDI   = 32'h00500093;
    localparam logic [31:0] I_ADDI30 = 32'h40000093;
    localparam logic [31:0] I_LW     = 32'h0000A103;
    localparam logic [31:0] I_SW     = 32'h0020A023;
    localparam logic [31:0] I_BNE    = 32'h00209063;
    localparam logic [31:0] I_BEQ    = 32'h00208063;
    localparam logic [31:0] I_BLT    = 32'h0020C063;
    localparam logic [31:0] I_SUB    = 32'h402081B3;
    localparam logic [31:0] I_SRAI   = 32'h4010D093;
    localparam logic [31:0] I_JAL    = 32'h000000EF;
    localparam logic [31:0] I_JALR   = 32'h000100E7;
    localparam logic [31:0] I_LUI    = 32'h000012B7;
    localparam logic [31:0] I_AUIPC  = 32'h00001297;
    localparam logic [31:0] I_ILL    = 32'h0000007F;
    localparam logic [31:0] I_BRILL  = 32'h0020A063;

    logic clk = 1'b0;
    logic rst, ena, mem_ready, equal, alu_lt, alu_ltu;
    logic [31:0] instruction;
    logic mem_req, mem_wr_ena, pc_ena, ir_write, reg_write, adr_src, halted;
    logic [1:0] alu_src_a, alu_src_b, result_src, fault;
    logic [2:0] imm_src;
    alu_control_t alu_control;

    always #5 clk = ~clk;

    rv32i_mc_control_unit #(.MEM_TIMEOUT(16), .TRAP_ILLEGAL(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .ena_i(ena), .instruction_i(instruction),
        .mem_ready_i(mem_ready), .equal_i(equal), .alu_lt_i(alu_lt), .alu_ltu_i(alu_ltu),
        .mem_req_o(mem_req), .mem_wr_ena_o(mem_wr_ena), .pc_ena_o(pc_ena),
        .ir_write_o(ir_write), .reg_write_o(reg_write), .adr_src_o(adr_src),
        .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .result_src_o(result_src),
        .imm_src_o(imm_src), .alu_control_o(alu_control), .halted_o(halted), .fault_o(fault)
    );

    typedef struct packed {
        logic       req, wr, pc, irw, rw, adr;
        logic [1:0] sa, sb, rs;
        logic [2:0] imm;
        logic [3:0] alu;
        logic       hlt;
        logic [1:0] flt;
    } out_t;

    typedef struct {
        logic        rst, ena, rdy, eq, lt, ltu;
        logic [31:0] instr;
        out_t        exp;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   failures = 0;

    function automatic out_t mk(logic req, logic wr, logic pc, logic irw, logic rw, logic adr,
                                logic [1:0] sa, logic [1:0] sb, logic [1:0] rs, logic [2:0] imm,
                                alu_control_t alu, logic hlt, logic [1:0] flt);
        out_t o;
        o = '{req:req, wr:wr, pc:pc, irw:irw, rw:rw, adr:adr, sa:sa, sb:sb, rs:rs,
              imm:imm, alu:alu, hlt:hlt, flt:flt};
        return o;
    endfunction

    function automatic out_t o_fetch(logic rdy);  return mk(1,0,rdy,rdy,0,0,2'b00,2'b10,2'b10,3'b000,ALU_ADD,0,2'b00); endfunction
    function automatic out_t o_dec(logic [2:0] i); return mk(0,0,0,0,0,0,2'b01,2'b01,2'b00,i,ALU_ADD,0,2'b00); endfunction
    function automatic out_t o_madr(logic [2:0] i); return mk(0,0,0,0,0,0,2'b10,2'b01,2'b00,i,ALU_ADD,0,2'b00); endfunction
    function automatic out_t o_mrd();             return mk(1,0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,ALU_ADD,0,2'b00); endfunction
    function automatic out_t o_mwb();             return mk(0,0,0,0,1,0,2'b00,2'b00,2'b01,3'b000,ALU_ADD,0,2'b00); endfunction
    function automatic out_t o_mwr(logic rdy);    return mk(1,rdy,0,0,0,1,2'b00,2'b00,2'b00,3'b000,ALU_ADD,0,2'b00); endfunction
    function automatic out_t o_exr(alu_control_t a); return mk(0,0,0,0,0,0,2'b10,2'b00,2'b00,3'b000,a,0,2'b00); endfunction
    function automatic out_t o_exi(alu_control_t a); return mk(0,0,0,0,0,0,2'b10,2'b01,2'b00,3'b000,a,0,2'b00); endfunction
    function automatic out_t o_awb();             return mk(0,0,0,0,1,0,2'b00,2'b00,2'b00,3'b000,ALU_ADD,0,2'b00); endfunction
    function automatic out_t o_jal();             return mk(0,0,1,0,0,0,2'b01,2'b10,2'b00,3'b000,ALU_ADD,0,2'b00); endfunction
    function automatic out_t o_jalr();            return mk(0,0,1,0,0,0,2'b10,2'b01,2'b10,3'b000,ALU_ADD,0,2'b00); endfunction
    function automatic out_t o_link();            return mk(0,0,0,0,0,0,2'b01,2'b10,2'b00,3'b000,ALU_ADD,0,2'b00); endfunction
    function automatic out_t o_br(logic tk);      return mk(0,0,tk,0,0,0,2'b10,2'b00,2'b00,3'b000,ALU_SUB,0,2'b00); endfunction
    function automatic out_t o_lui();             return mk(0,0,0,0,0,0,2'b11,2'b01,2'b00,3'b011,ALU_ADD,0,2'b00); endfunction
    function automatic out_t o_auipc();           return mk(0,0,0,0,0,0,2'b01,2'b01,2'b00,3'b011,ALU_ADD,0,2'b00); endfunction
    function automatic out_t o_halt(logic [1:0] f); return mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,ALU_ADD,1,f); endfunction

    function automatic out_t off(out_t o);
        out_t r;
        r = o;
        r.req = 1'b0; r.wr = 1'b0; r.pc = 1'b0; r.irw = 1'b0; r.rw = 1'b0;
        return r;
    endfunction

    task automatic add(logic r, logic e, logic [31:0] ins, logic rdy, logic eq, logic lt, logic ltu, out_t exp);
        vec_t v;
        v.rst = r; v.ena = e; v.instr = ins; v.rdy = rdy; v.eq = eq; v.lt = lt; v.ltu = ltu; v.exp = exp;
        vecs.push_back(v);
    endtask

    function automatic out_t sample();
        return mk(mem_req, mem_wr_ena, pc_ena, ir_write, reg_write, adr_src, alu_src_a,
                  alu_src_b, result_src, imm_src, alu_control, halted, fault);
    endfunction

    task automatic step(logic r, logic e, logic [31:0] ins, logic rdy);
        @(negedge clk);
        rst = r; ena = e; instruction = ins; mem_ready = rdy;
        equal = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0;
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    initial begin
        out_t act;
        rst = 1'b0; ena = 1'b1; instruction = I_ADDI; mem_ready = 1'b0;
        equal = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0;
        repeat (2) @(posedge clk);

        // addi: reset cycle, then fetch/decode/exec/writeback with mem_ready always high
        add(0,1,I_ADDI,1,0,0,0, off(o_fetch(1)));
        add(1,1,I_ADDI,1,0,0,0, o_fetch(1));
        add(1,1,I_ADDI,1,0,0,0, o_dec(3'b100));
        add(1,1,I_ADDI,1,0,0,0, o_exi(ALU_ADD));
        add(1,1,I_ADDI,1,0,0,0, o_awb());
        // lw with three wait cycles in MEM_READ
        add(1,1,I_LW,1,0,0,0, o_fetch(1));
        add(1,1,I_LW,1,0,0,0, o_dec(3'b100));
        add(1,1,I_LW,1,0,0,0, o_madr(3'b000));
        add(1,1,I_LW,0,0,0,0, o_mrd());
        add(1,1,I_LW,0,0,0,0, o_mrd());
        add(1,1,I_LW,0,0,0,0, o_mrd());
        add(1,1,I_LW,1,0,0,0, o_mrd());
        add(1,1,I_LW,1,0,0,0, o_mwb());
        // sw with one wait cycle
        add(1,1,I_SW,1,0,0,0, o_fetch(1));
        add(1,1,I_SW,1,0,0,0, o_dec(3'b100));
        add(1,1,I_SW,1,0,0,0, o_madr(3'b001));
        add(1,1,I_SW,0,0,0,0, o_mwr(0));
        add(1,1,I_SW,1,0,0,0, o_mwr(1));
        // bne taken, beq not taken, blt taken
        add(1,1,I_BNE,1,0,0,0, o_fetch(1));
        add(1,1,I_BNE,1,0,0,0, o_dec(3'b010));
        add(1,1,I_BNE,1,0,0,0, o_br(1));
        add(1,1,I_BEQ,1,0,0,0, o_fetch(1));
        add(1,1,I_BEQ,1,0,0,0, o_dec(3'b010));
        add(1,1,I_BEQ,1,0,0,0, o_br(0));
        add(1,1,I_BLT,1,1,1,0, o_fetch(1));
        add(1,1,I_BLT,1,1,1,0, o_dec(3'b010));
        add(1,1,I_BLT,1,1,1,0, o_br(1));
        // sub with a five-cycle ena stall in EXEC_R
        add(1,1,I_SUB,1,0,0,0, o_fetch(1));
        add(1,1,I_SUB,1,0,0,0, o_dec(3'b100));
        for (int i = 0; i < 5; i++) add(1,0,I_SUB,1,0,0,0, off(o_exr(ALU_SUB)));
        add(1,1,I_SUB,1,0,0,0, o_exr(ALU_SUB));
        add(1,1,I_SUB,1,0,0,0, o_awb());
        // srai, with an ena stall on a ready fetch
        add(1,0,I_SRAI,1,0,0,0, off(o_fetch(1)));
        add(1,1,I_SRAI,1,0,0,0, o_fetch(1));
        add(1,1,I_SRAI,1,0,0,0, o_dec(3'b100));
        add(1,1,I_SRAI,1,0,0,0, o_exi(ALU_SRA));
        add(1,1,I_SRAI,1,0,0,0, o_awb());
        // jal, jalr, lui, auipc, addi with bit 30 set
        add(1,1,I_JAL,1,0,0,0, o_fetch(1));
        add(1,1,I_JAL,1,0,0,0, o_dec(3'b100));
        add(1,1,I_JAL,1,0,0,0, o_jal());
        add(1,1,I_JAL,1,0,0,0, o_awb());
        add(1,1,I_JALR,1,0,0,0, o_fetch(1));
        add(1,1,I_JALR,1,0,0,0, o_dec(3'b100));
        add(1,1,I_JALR,1,0,0,0, o_jalr());
        add(1,1,I_JALR,1,0,0,0, o_link());
        add(1,1,I_JALR,1,0,0,0, o_awb());
        add(1,1,I_LUI,1,0,0,0, o_fetch(1));
        add(1,1,I_LUI,1,0,0,0, o_dec(3'b100));
        add(1,1,I_LUI,1,0,0,0, o_lui());
        add(1,1,I_LUI,1,0,0,0, o_awb());
        add(1,1,I_AUIPC,1,0,0,0, o_fetch(1));
        add(1,1,I_AUIPC,1,0,0,0, o_dec(3'b100));
        add(1,1,I_AUIPC,1,0,0,0, o_auipc());
        add(1,1,I_AUIPC,1,0,0,0, o_awb());
        add(1,1,I_ADDI30,1,0,0,0, o_fetch(1));
        add(1,1,I_ADDI30,1,0,0,0, o_dec(3'b100));
        add(1,1,I_ADDI30,1,0,0,0, o_exi(ALU_ADD));
        add(1,1,I_ADDI30,1,0,0,0, o_awb());
        // illegal opcode, then illegal branch funct3
        add(1,1,I_ILL,1,0,0,0, o_fetch(1));
        add(1,1,I_ILL,1,0,0,0, o_dec(3'b100));
        add(1,1,I_ILL,1,0,0,0, o_halt(2'b01));
        add(1,1,I_ILL,1,0,0,0, o_halt(2'b01));
        add(0,1,I_ILL,1,0,0,0, o_halt(2'b01));
        add(1,1,I_BRILL,1,0,0,0, o_fetch(1));
        add(1,1,I_BRILL,1,0,0,0, o_dec(3'b010));
        add(1,1,I_BRILL,1,0,0,0, o_halt(2'b01));
        add(0,1,I_BRILL,1,0,0,0, o_halt(2'b01));
        // reset in MEM_WRITE with mem_ready high
        add(1,1,I_SW,1,0,0,0, o_fetch(1));
        add(1,1,I_SW,1,0,0,0, o_dec(3'b100));
        add(1,1,I_SW,1,0,0,0, o_madr(3'b001));
        add(0,1,I_SW,1,0,0,0, off(o_mwr(1)));
        add(1,1,I_SW,0,0,0,0, o_fetch(0));

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; ena = vecs[i].ena; instruction = vecs[i].instr;
            mem_ready = vecs[i].rdy; equal = vecs[i].eq; alu_lt = vecs[i].lt; alu_ltu = vecs[i].ltu;
            #1;
            act = sample();
            checks++;
            if (act !== vecs[i].exp) begin
                failures++;
                $display("FAIL vec%0d actual=%h expected=%h", i, act, vecs[i].exp);
            end
        end

        // Fetch timeout: stalled cycles must not count, then 16 waiting cycles trap.
        step(0,1,I_LW,0);
        for (int i = 0; i < 3; i++) begin
            step(1,0,I_LW,0);
            chk("to_stall_req", {31'd0, mem_req}, 32'd0);
        end
        for (int i = 0; i < 16; i++) begin
            step(1,1,I_LW,0);
            chk($sformatf("to_wait%0d", i), {30'd0, halted, mem_req}, 32'd1);
        end
        step(1,1,I_LW,0);
        chk("to_halt", {29'd0, halted, fault}, {29'd0, 1'b1, 2'b10});
        chk("to_req", {31'd0, mem_req}, 32'd0);
        step(1,1,I_LW,1);
        chk("to_sticky", {28'd0, halted, ir_write, fault}, {28'd0, 1'b1, 1'b0, 2'b10});

        // Wait count restarts per memory state: 10 waits in FETCH plus 15 in MEM_READ is no fault.
        step(0,1,I_LW,0);
        for (int i = 0; i < 10; i++) step(1,1,I_LW,0);
        step(1,1,I_LW,1);
        chk("clr_irw", {31'd0, ir_write}, 32'd1);
        step(1,1,I_LW,1);
        step(1,1,I_LW,1);
        for (int i = 0; i < 15; i++) begin
            step(1,1,I_LW,0);
            chk($sformatf("clr_wait%0d", i), {29'd0, mem_req, adr_src, halted}, {29'd0, 3'b110});
        end
        step(1,1,I_LW,1);
        chk("clr_last", {31'd0, mem_req}, 32'd1);
        step(1,1,I_LW,1);
        chk("clr_wb", {28'd0, reg_write, halted, fault}, {28'd0, 1'b1, 1'b0, 2'b00});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
